// File: rtl/ms_timer_scheduler.sv
// ms_timer_scheduler: one shared 1 ms prescaler plus four one-shot
// millisecond countdown channels.
//
// A round-robin arbiter loads at most one channel per cycle. Every running
// channel counts down on the edge that samples tick_1ms high. done pulses
// one cycle as the count expires. All outputs come straight from registers.
module ms_timer_scheduler #(
    parameter int TICK_DIV = 50000,
    parameter int DW       = 10
) (
    input  logic            clk_50mhz,
    input  logic            reset,
    input  logic [3:0]      req,
    input  logic [4*DW-1:0] req_ms,
    input  logic [3:0]      cancel,
    output logic [3:0]      grant,
    output logic [3:0]      busy,
    output logic [3:0]      done,
    output logic            tick_1ms,
    output logic [DW-1:0]   ms_count
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    // Pick the first eligible channel, searching from ptr upward modulo 4.
    function automatic logic [3:0] rr_pick(input logic [3:0] elig, input logic [1:0] ptr);
        logic [3:0] g;
        logic [1:0] idx;
        logic       found;
        g     = 4'b0000;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && elig[idx]) begin
                g[idx] = 1'b1;
                found  = 1'b1;
            end else begin
                found = found;
            end
        end
        return g;
    endfunction

    logic [PW-1:0] presc_r;
    logic          tick_r;
    logic [DW-1:0] ms_count_r;
    logic          wrap_s;

    logic [1:0]    rr_r;
    logic [1:0]    rr_nxt_s;
    logic [3:0]    eligible_s;
    logic [3:0]    gnt_s;

    logic [DW-1:0] rem_r     [4];
    logic [DW-1:0] rem_nxt_s [4];
    logic [3:0]    busy_r;
    logic [3:0]    busy_nxt_s;
    logic [3:0]    done_r;
    logic [3:0]    done_nxt_s;
    logic [3:0]    grant_r;

    assign wrap_s = (presc_r == PRESC_MAX);

    // Shared prescaler: wrap every TICK_DIV cycles, pulse tick and bump ms_count.
    always_ff @(posedge clk_50mhz) begin
        if (!reset) begin
            presc_r    <= '0;
            tick_r     <= 1'b0;
            ms_count_r <= '0;
        end else if (wrap_s) begin
            presc_r    <= '0;
            tick_r     <= 1'b1;
            ms_count_r <= ms_count_r + DW'(1);
        end else begin
            presc_r    <= presc_r + PW'(1);
            tick_r     <= 1'b0;
            ms_count_r <= ms_count_r;
        end
    end

    // Round-robin grant selection among idle requesters and the next pointer.
    always_comb begin
        eligible_s = req & ~busy_r;
        gnt_s      = rr_pick(eligible_s, rr_r);
        case (gnt_s)
            4'b0001: rr_nxt_s = 2'd1;
            4'b0010: rr_nxt_s = 2'd2;
            4'b0100: rr_nxt_s = 2'd3;
            4'b1000: rr_nxt_s = 2'd0;
            default: rr_nxt_s = rr_r;
        endcase
    end

    // Per-channel next state: a grant loads the channel, a cancel of a running
    // timer beats a tick that arrives on the same edge, and a tick counts the
    // channel down. A channel granted on a tick edge is idle at sample time,
    // so its fresh value is never decremented by that tick.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            rem_nxt_s[i]  = rem_r[i];
            busy_nxt_s[i] = busy_r[i];
            done_nxt_s[i] = 1'b0;
            if (gnt_s[i]) begin
                rem_nxt_s[i] = req_ms[DW*i +: DW];
                if (req_ms[DW*i +: DW] != '0) begin
                    busy_nxt_s[i] = 1'b1;
                end else begin
                    done_nxt_s[i] = 1'b1;
                end
            end else if (busy_r[i] && cancel[i]) begin
                rem_nxt_s[i]  = '0;
                busy_nxt_s[i] = 1'b0;
            end else if (busy_r[i] && tick_r) begin
                if (rem_r[i] > DW'(1)) begin
                    rem_nxt_s[i] = rem_r[i] - DW'(1);
                end else begin
                    rem_nxt_s[i]  = '0;
                    busy_nxt_s[i] = 1'b0;
                    done_nxt_s[i] = 1'b1;
                end
            end else begin
                rem_nxt_s[i] = rem_r[i];
            end
        end
    end

    // Arbiter pointer, channel state and registered grant/done pulses.
    always_ff @(posedge clk_50mhz) begin
        if (!reset) begin
            rr_r    <= 2'd0;
            busy_r  <= 4'b0000;
            done_r  <= 4'b0000;
            grant_r <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                rem_r[i] <= '0;
            end
        end else begin
            rr_r    <= rr_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
            grant_r <= gnt_s;
            for (int i = 0; i < 4; i++) begin
                rem_r[i] <= rem_nxt_s[i];
            end
        end
    end

    assign grant    = grant_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign tick_1ms = tick_r;
    assign ms_count = ms_count_r;

endmodule
